// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } alu_arb_state_t;

    localparam int ALU_ARB_DATA_W = 32;
    localparam int ALU_ARB_OP_W   = 3;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;

    // Converts a one-hot 2-way grant into the requester index.
    function automatic logic gnt_to_id(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way grant generator: round-robin by default, fixed priority when
// ALU_ARB_FIXED_PRIO_EN is defined.
module alu_arb_rr
    import alu_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0];
        gnt[1] = req[1] & ~req[0];
    end
`else
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two command sources onto one combinational ALU and returns tagged responses.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = ALU_ARB_DATA_W,
    parameter int OP_W   = ALU_ARB_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_res,
    output logic              rsp_co,
    output logic              rsp_zero,
    output logic              rsp_ovf,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_co,
    input  logic              alu_zero,
    input  logic              alu_ovf
);

    alu_arb_state_t state_q, state_d;

    // Holds readies low until the first clock edge after reset release.
    logic en_q, en_d;

    logic              gnt_id_q, gnt_id_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_res_q, rsp_res_d;
    logic              rsp_co_q, rsp_co_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_ovf_q, rsp_ovf_d;

    logic [1:0] gnt;
    logic       last_grant;
    logic       xfer;

    alu_arb_rr u_rr (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign last_grant = 1'b0;
`else
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (xfer) begin
            last_grant_d = gnt_to_id(gnt);
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = 1'b1;
        case (state_q)
            ST_IDLE: if (xfer)      state_d = ST_EXEC;
            ST_EXEC:                state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        if (state_q == ST_IDLE && en_q) begin
            req0_ready = gnt[0];
            req1_ready = gnt[1];
        end
        if (state_q == ST_RESP) begin
            rsp_valid = 1'b1;
        end
    end

    assign xfer = req0_ready | req1_ready;

    always_comb begin
        gnt_id_d = gnt_id_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        if (xfer) begin
            gnt_id_d = gnt_to_id(gnt);
            alu_op_d = gnt[1] ? req1_op : req0_op;
            alu_a_d  = gnt[1] ? req1_a  : req0_a;
            alu_b_d  = gnt[1] ? req1_b  : req0_b;
        end
    end

    // The ALU has had a full stable cycle by the end of EXEC.
    always_comb begin
        rsp_id_d   = rsp_id_q;
        rsp_res_d  = rsp_res_q;
        rsp_co_d   = rsp_co_q;
        rsp_zero_d = rsp_zero_q;
        rsp_ovf_d  = rsp_ovf_q;
        if (state_q == ST_EXEC) begin
            rsp_id_d   = gnt_id_q;
            rsp_res_d  = alu_res;
            rsp_co_d   = alu_co;
            rsp_zero_d = alu_zero;
            rsp_ovf_d  = alu_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_id_q   <= 1'b0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rsp_id_q   <= 1'b0;
            rsp_res_q  <= '0;
            rsp_co_q   <= 1'b0;
            rsp_zero_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            gnt_id_q   <= gnt_id_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            rsp_id_q   <= rsp_id_d;
            rsp_res_q  <= rsp_res_d;
            rsp_co_q   <= rsp_co_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_ovf_q  <= rsp_ovf_d;
        end
    end

    assign alu_op   = alu_op_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_res  = rsp_res_q;
    assign rsp_co   = rsp_co_q;
    assign rsp_zero = rsp_zero_q;
    assign rsp_ovf  = rsp_ovf_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 32-bit ALU attached.
// Honours ALU_ARB_FIXED_PRIO_EN for the tie-break expectations.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_res;
    logic        rsp_co, rsp_zero, rsp_ovf;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_res;
    logic        alu_co, alu_zero, alu_ovf;

    int n_vec = 0;
    int n_err = 0;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam logic TIE2_ID = 1'b0;
`else
    localparam logic TIE2_ID = 1'b1;
`endif

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_res    (rsp_res),
        .rsp_co     (rsp_co),
        .rsp_zero   (rsp_zero),
        .rsp_ovf    (rsp_ovf),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_res    (alu_res),
        .alu_co     (alu_co),
        .alu_zero   (alu_zero),
        .alu_ovf    (alu_ovf)
    );

    // Behavioural stand-in for the external combinational ALU.
    always_comb begin
        logic [32:0] sum;
        sum     = 33'd0;
        alu_res = 32'd0;
        alu_co  = 1'b0;
        alu_ovf = 1'b0;
        case (alu_op)
            3'b000: alu_res = alu_a & alu_b;
            3'b001: alu_res = alu_a | alu_b;
            3'b010: begin
                sum     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_res = sum[31:0];
                alu_co  = sum[32];
                alu_ovf = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            3'b110: begin
                alu_res = alu_a - alu_b;
                alu_co  = alu_a >= alu_b;
                alu_ovf = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            default: alu_res = 32'd0;
        endcase
        alu_zero = (alu_res == 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_any_ready(input string tag);
        int n;
        n = 0;
        #1;
        while (!(req0_ready === 1'b1 || req1_ready === 1'b1) && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 20), 32'd1);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = ALU_OP_AND; req1_op = ALU_OP_AND;
        req0_a = 32'h0; req0_b = 32'h0; req1_a = 32'h0; req1_b = 32'h0;
        rsp_ready = 1'b1;

        // Reset state, with both requests pending and rsp_ready high
        tick();
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_id",     32'(rsp_id),     32'd0);
        chk("rst_rsp_res",    rsp_res,         32'd0);
        chk("rst_flags",      32'({rsp_co, rsp_zero, rsp_ovf}), 32'd0);
        chk("rst_alu_op",     32'(alu_op),     32'd0);
        chk("rst_alu_a",      alu_a,           32'd0);
        chk("rst_alu_b",      alu_b,           32'd0);
        do_reset();

        // Single ADD from requester 0
        req0_valid = 1'b1; req0_op = ALU_OP_ADD;
        req0_a = 32'h01234567; req0_b = 32'h76543210;
        wait_any_ready("add_ready_timeout");
        chk("add_req0_ready", 32'(req0_ready), 32'd1);
        chk("add_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("add_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("add_alu_a",  alu_a, 32'h01234567);
        chk("add_alu_b",  alu_b, 32'h76543210);
        chk("add_alu_op", 32'(alu_op), 32'(ALU_OP_ADD));
        tick();
        chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("add_rsp_id",    32'(rsp_id),    32'd0);
        chk("add_rsp_res",   rsp_res,        32'h77777777);
        chk("add_rsp_zero",  32'(rsp_zero),  32'd0);
        tick();
        chk("add_rsp_done",  32'(rsp_valid), 32'd0);
        chk("add_alu_hold",  alu_a, 32'h01234567);

        // Ties from a fresh reset
        do_reset();
        req0_valid = 1'b1; req0_op = ALU_OP_AND; req0_a = 32'hA5A5A5A5; req0_b = 32'h5A5A5A5A;
        req1_valid = 1'b1; req1_op = ALU_OP_AND; req1_a = 32'hA5A5A5A5; req1_b = 32'h5A5A5A5A;
        wait_any_ready("tie1_ready_timeout");
        chk("tie1_req0_ready", 32'(req0_ready), 32'd1);
        chk("tie1_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        tick();
        chk("tie1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tie1_rsp_id",    32'(rsp_id),    32'd0);
        chk("tie1_rsp_res",   rsp_res,        32'h0);
        chk("tie1_rsp_zero",  32'(rsp_zero),  32'd1);
        chk("tie1_resp_readies", 32'({req0_ready, req1_ready}), 32'd0);
        tick();
        chk("tie2_req1_ready", 32'(req1_ready), 32'(TIE2_ID));
        chk("tie2_req0_ready", 32'(req0_ready), 32'(!TIE2_ID));
        tick();
        tick();
        chk("tie2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tie2_rsp_id",    32'(rsp_id),    32'(TIE2_ID));
        chk("tie2_rsp_res",   rsp_res,        32'h0);
        tick();
        chk("tie3_req0_ready", 32'(req0_ready), 32'd1);
        chk("tie3_req1_ready", 32'(req1_ready), 32'd0);
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("tie3_rsp_id", 32'(rsp_id), 32'd0);

        // Backpressure: hold rsp_ready low for five cycles in RESP
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_id",    32'(rsp_id),    32'd0);
            chk("bp_rsp_zero",  32'(rsp_zero),  32'd1);
            chk("bp_readies",   32'({req0_ready, req1_ready}), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_ready", 32'(req0_ready | req1_ready), 32'd1);
        chk("bp_release_req1",  32'(req1_ready), 32'(TIE2_ID));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Reset asserted during EXEC discards the operation
        req0_valid = 1'b1; req0_op = ALU_OP_SUB; req0_a = 32'd5; req0_b = 32'd3;
        wait_any_ready("rexec_ready_timeout");
        tick();
        req0_valid = 1'b0;
        chk("rexec_in_exec_alu_a", alu_a, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("rexec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rexec_alu_a",     alu_a,          32'd0);
        chk("rexec_alu_op",    32'(alu_op),    32'd0);
        chk("rexec_rsp_res",   rsp_res,        32'd0);
        chk("rexec_readies",   32'({req0_ready, req1_ready}), 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rexec_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Signed overflow on ADD
        req0_valid = 1'b1; req0_op = ALU_OP_ADD; req0_a = 32'h7FFFFFFF; req0_b = 32'd1;
        wait_any_ready("ovf_ready_timeout");
        tick();
        req0_valid = 1'b0;
        tick();
        chk("ovf_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ovf_rsp_res",   rsp_res,        32'h80000000);
        chk("ovf_rsp_ovf",   32'(rsp_ovf),   32'd1);
        chk("ovf_rsp_co",    32'(rsp_co),    32'd0);
        tick();

        // SUB from requester 1 alone
        req1_valid = 1'b1; req1_op = ALU_OP_SUB; req1_a = 32'd5; req1_b = 32'd7;
        wait_any_ready("sub_ready_timeout");
        chk("sub_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("sub_rsp_id",  32'(rsp_id),  32'd1);
        chk("sub_rsp_res", rsp_res,      32'hFFFFFFFE);
        chk("sub_rsp_ovf", 32'(rsp_ovf), 32'd0);
        tick();
        chk("sub_rsp_done", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
